lamp_fpu_sqrt_post: RTL



---
 rtl/lamp_fpu_sqrt_post.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lamp_fpu_sqrt_post.sv
// lampFPU sqrt post stage: normalize, round and pack the fraction result.
// LAMP_FPU_SQRT_RNE_EN selects round-to-nearest-even; otherwise truncation.
module lamp_fpu_sqrt_post #(
    parameter int FLOAT_DW = 16,
    parameter int E_DW     = 8,
    parameter int F_DW     = 7,
    parameter int RES_DW   = 16,
    parameter int EXP_DW   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [RES_DW-1:0]   res_i,
    input  logic [EXP_DW-1:0]   exp_i,
    input  logic                sign_i,
    input  logic [1:0]          spec_i,
    output logic                valid_o,
    output logic [FLOAT_DW-1:0] result_o,
    output logic                ovf_o,
    output logic                unf_o,
    output logic                inx_o,
    output logic                err_o
);

    localparam int EF_W = EXP_DW + 2;

    localparam logic [1:0] SPEC_NORM = 2'b00;
    localparam logic [1:0] SPEC_QNAN = 2'b01;
    localparam logic [1:0] SPEC_INF  = 2'b10;
    localparam logic [1:0] SPEC_ZERO = 2'b11;

    localparam logic signed [EXP_DW:0] ADJ_M1 = '1;
    localparam logic signed [EXP_DW:0] ADJ_M2 = {{EXP_DW{1'b1}}, 1'b0};

    localparam logic signed [EF_W-1:0] EMAX  = EF_W'(255);
    localparam logic signed [EF_W-1:0] EZERO = '0;

    localparam logic [FLOAT_DW-1:0] QNAN_VAL =
        {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

    typedef struct packed {
        logic                     sign;
        logic [1:0]               spec;
        logic                     err;
        logic [F_DW-1:0]          mant;
        logic                     guard;
        logic                     sticky;
        logic signed [EXP_DW:0]   e1;
    } s1_t;

    // ---------------- stage 1: leading-one select ----------------
    s1_t                    s1_n;
    s1_t                    s1;
    logic                   v1;
    logic signed [EXP_DW:0] adj;

    always_comb begin
        s1_n      = '0;
        adj       = '0;
        s1_n.sign = sign_i;
        s1_n.spec = spec_i;
        priority case (1'b1)
            res_i[RES_DW-1]: begin
                s1_n.mant   = res_i[RES_DW-2 -: F_DW];
                s1_n.guard  = res_i[RES_DW-2-F_DW];
                s1_n.sticky = |res_i[RES_DW-3-F_DW:0];
            end
            res_i[RES_DW-2]: begin
                s1_n.mant   = res_i[RES_DW-3 -: F_DW];
                s1_n.guard  = res_i[RES_DW-3-F_DW];
                s1_n.sticky = |res_i[RES_DW-4-F_DW:0];
                adj         = ADJ_M1;
            end
            res_i[RES_DW-3]: begin
                s1_n.mant   = res_i[RES_DW-4 -: F_DW];
                s1_n.guard  = res_i[RES_DW-4-F_DW];
                s1_n.sticky = |res_i[RES_DW-5-F_DW:0];
                adj         = ADJ_M2;
            end
            default: begin
                s1_n.err = 1'b1;
            end
        endcase
        s1_n.e1 = {exp_i[EXP_DW-1], exp_i} + adj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= valid_i;
            if (valid_i) begin
                s1 <= s1_n;
            end
        end
    end

    // ---------------- stage 2: round, range check, pack ----------------
    logic                   carry;
    logic [F_DW-1:0]        mant_r;
    logic signed [EF_W-1:0] ef;
    logic                   inx_raw;

`ifdef LAMP_FPU_SQRT_RNE_EN
    logic rnd;

    always_comb begin
        rnd             = s1.guard & (s1.sticky | s1.mant[0]);
        // carry out of the mantissa means {1,mant} rolled over to 2.0
        {carry, mant_r} = {1'b0, s1.mant} + {{F_DW{1'b0}}, rnd};
    end
`else
    always_comb begin
        carry  = 1'b0;
        mant_r = s1.mant;
    end
`endif

    always_comb begin
        ef      = {s1.e1[EXP_DW], s1.e1} + {{(EF_W-1){1'b0}}, carry};
        inx_raw = s1.guard | s1.sticky;
    end

    logic [FLOAT_DW-1:0] res_n;
    logic                ovf_n;
    logic                unf_n;
    logic                inx_n;
    logic                err_n;

    always_comb begin
        res_n = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        inx_n = 1'b0;
        err_n = 1'b0;
        unique case (s1.spec)
            SPEC_QNAN: res_n = QNAN_VAL;
            SPEC_INF:  res_n = {s1.sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
            SPEC_ZERO: res_n = {s1.sign, {(E_DW+F_DW){1'b0}}};
            SPEC_NORM: begin
                if (s1.err) begin
                    err_n = 1'b1;
                end else if (ef >= EMAX) begin
                    res_n = {s1.sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
                    ovf_n = 1'b1;
                    inx_n = 1'b1;
                end else if (ef <= EZERO) begin
                    // no subnormals: anything below the normal range flushes
                    res_n = {s1.sign, {(E_DW+F_DW){1'b0}}};
                    unf_n = 1'b1;
                    inx_n = 1'b1;
                end else begin
                    res_n = {s1.sign, ef[E_DW-1:0], mant_r};
                    inx_n = inx_raw;
                end
            end
            default: res_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            ovf_o    <= 1'b0;
            unf_o    <= 1'b0;
            inx_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= v1;
            if (v1) begin
                result_o <= res_n;
                ovf_o    <= ovf_n;
                unf_o    <= unf_n;
                inx_o    <= inx_n;
                err_o    <= err_n;
            end
        end
    end

endmodule
